// File: rtl/wave_trigger_capture.sv
// -----------------------------------------------------------------------------
// wave_trigger_capture
//
// Capture front end for the waveform display. It watches the signed 16-bit
// audio stream for a positive-going zero crossing. It then writes
// 2**NUM_SAMPLES_LOG2 consecutive samples, converted to 8-bit offset binary,
// into the half of the double-buffered sample RAM that the display is not
// reading. After the capture it waits for the display to go idle and then
// flips read_index, so the display picks up the fresh half.
//
// Optional feature (compile-time macro WAVE_TRIGGER_HYST_EN):
//   When the macro is defined, a crossing only triggers after a sample at or
//   below -HYST_LEVEL has been seen while armed. This rejects triggers caused
//   by small noise around zero. When the macro is undefined, a plain sign
//   change triggers the capture.
//
// Parameters:
//   NUM_SAMPLES_LOG2  log2 of the number of samples per capture
//   HYST_LEVEL        magnitude below zero required to re-arm (feature only)
//
// Ports:
//   clk                input   system clock, sole clock domain
//   reset              input   asynchronous, active-high, clears all state
//   new_sample_ready   input   one-cycle strobe, new_sample_in valid
//   new_sample_in      input   signed two's-complement audio sample
//   wave_display_idle  input   display is not reading the RAM (from ~vsync)
//   write_address      output  {~read_index, sample_count}
//   write_enable       output  RAM write strobe, one cycle per sample
//   write_sample       output  {~sample[15], sample[14:8]}
//   read_index         output  buffer half the display reads
// -----------------------------------------------------------------------------
module wave_trigger_capture #(
   parameter int unsigned NUM_SAMPLES_LOG2 = 8,
   parameter logic [15:0] HYST_LEVEL       = 16'd1024
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        new_sample_ready,
   input  logic signed [15:0]          new_sample_in,
   input  logic                        wave_display_idle,
   output logic [NUM_SAMPLES_LOG2:0]   write_address,
   output logic                        write_enable,
   output logic [7:0]                  write_sample,
   output logic                        read_index
);

   typedef enum logic [1:0] {
      ST_ARMED  = 2'd0,
      ST_ACTIVE = 2'd1,
      ST_WAIT   = 2'd2
   } state_t;

   localparam logic [NUM_SAMPLES_LOG2-1:0] ZERO_COUNT = '0;
   localparam logic [NUM_SAMPLES_LOG2-1:0] ONE_COUNT  = ZERO_COUNT + 1'b1;
   localparam logic [NUM_SAMPLES_LOG2-1:0] LAST_COUNT = '1;

   // Re-arm threshold as a 17-bit signed value so that HYST_LEVEL = 32768
   // still yields a representable -32768 bound.
   localparam logic signed [16:0] HYST_THRESH = -$signed({1'b0, HYST_LEVEL});

   state_t                       r_state;
   logic [NUM_SAMPLES_LOG2-1:0]  r_sample_count;
   // Only the sign of the previous sample matters for crossing detection,
   // so only that bit is kept.
   logic                         r_prev_neg;

`ifdef WAVE_TRIGGER_HYST_EN
   logic                         r_armed_low;
`endif

   logic                         w_crossing;
   logic                         w_trigger;
   logic                         w_write;

   // Map the upper byte of a signed sample to offset binary:
   // -32768 -> 0x00, 0 -> 0x80, 32767 -> 0xFF.
   function automatic logic [7:0] to_offset_binary(input logic [7:0] hi_byte);
      return {~hi_byte[7], hi_byte[6:0]};
   endfunction

   // True when the sample is at or below the negative re-arm threshold.
   function automatic logic is_deep_negative(input logic signed [15:0] s);
      logic signed [16:0] s_ext;
      s_ext = 17'(s);
      return (s_ext <= HYST_THRESH);
   endfunction

   assign w_crossing = new_sample_ready & r_prev_neg & ~new_sample_in[15];

`ifdef WAVE_TRIGGER_HYST_EN
   assign w_trigger = w_crossing & r_armed_low;
`else
   assign w_trigger = w_crossing;
`endif

   // A write happens on the triggering sample in ARMED and on every strobe
   // in ACTIVE. In ARMED the count is always zero, so both cases share the
   // same address expression.
   assign w_write = ((r_state == ST_ARMED)  & w_trigger) |
                    ((r_state == ST_ACTIVE) & new_sample_ready);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state        <= ST_ARMED;
         r_sample_count <= ZERO_COUNT;
         r_prev_neg     <= 1'b0;
         write_enable   <= 1'b0;
         write_address  <= '0;
         write_sample   <= 8'h00;
         read_index     <= 1'b0;
`ifdef WAVE_TRIGGER_HYST_EN
         r_armed_low    <= 1'b0;
`endif
      end else begin
         write_enable <= 1'b0;

         if (new_sample_ready) begin
            r_prev_neg <= new_sample_in[15];
         end

         if (w_write) begin
            write_enable  <= 1'b1;
            write_address <= {~read_index, r_sample_count};
            write_sample  <= to_offset_binary(new_sample_in[15:8]);
         end

         case (r_state)
            ST_ARMED: begin
`ifdef WAVE_TRIGGER_HYST_EN
               if (new_sample_ready && is_deep_negative(new_sample_in)) begin
                  r_armed_low <= 1'b1;
               end
`endif
               if (w_trigger) begin
                  r_sample_count <= ONE_COUNT;
                  r_state        <= ST_ACTIVE;
               end
            end

            ST_ACTIVE: begin
               if (new_sample_ready) begin
                  // The last slot wraps the count back to zero, ready for
                  // the next capture.
                  r_sample_count <= r_sample_count + ONE_COUNT;
                  if (r_sample_count == LAST_COUNT) begin
                     r_state <= ST_WAIT;
                  end
               end
            end

            ST_WAIT: begin
               // Flip halves only here, so the display never sees a
               // partially written buffer.
               if (wave_display_idle) begin
                  read_index <= ~read_index;
                  r_state    <= ST_ARMED;
`ifdef WAVE_TRIGGER_HYST_EN
                  r_armed_low <= 1'b0;
`endif
               end
            end

            default: begin
               r_state <= ST_ARMED;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wave_trigger_capture.sv
module tb_wave_trigger_capture;

   localparam int N    = 256;
   localparam int HYST = 1024;

   logic               clk = 1'b0;
   logic               reset;
   logic               ready;
   logic signed [15:0] sample;
   logic               idle;
   logic [8:0]         waddr;
   logic               we;
   logic [7:0]         wdata;
   logic               rd;

   wave_trigger_capture dut (
      .clk               (clk),
      .reset             (reset),
      .new_sample_ready  (ready),
      .new_sample_in     (sample),
      .wave_display_idle (idle),
      .write_address     (waddr),
      .write_enable      (we),
      .write_sample      (wdata),
      .read_index        (rd)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: m_pos counts samples already stored in the current
   // buffer (0 = waiting for a trigger, N = buffer full, waiting for idle).
   int m_pos;
   int m_prev;
   int m_rd;
   bit m_low;
   bit e_we;
   int e_addr;
   int e_data;

   typedef struct {
      bit r;
      int s;
      bit id;
      bit we;
      int addr;
      int data;
      bit rd;
   } vec_t;

   vec_t tbl[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      m_pos  = 0;
      m_prev = 0;
      m_rd   = 0;
      m_low  = 0;
   endtask

   task automatic model_step(input bit r, input int s, input bit id);
      bit was_full;
      bit trig;
      was_full = (m_pos == N);
      e_we = 0;
      if (r) begin
         trig = (m_pos == 0) && (m_prev < 0) && (s >= 0);
`ifdef WAVE_TRIGGER_HYST_EN
         trig = trig && m_low;
         if (m_pos == 0 && s <= -HYST) m_low = 1;
`endif
         if (trig || (m_pos > 0 && m_pos < N)) begin
            e_we   = 1;
            e_addr = (1 - m_rd) * N + m_pos;
            e_data = (s + 32768) / 256;
            m_pos++;
         end
         m_prev = s;
      end
      if (was_full && id) begin
         m_rd  = m_rd ^ 1;
         m_pos = 0;
         m_low = 0;
      end
   endtask

   // Drive one clock cycle and leave the bench 1 time unit after the edge.
   task automatic tick(input bit r, input int s, input bit id);
      @(negedge clk);
      model_step(r, s, id);
      ready  = r;
      sample = 16'(s);
      idle   = id;
      @(posedge clk);
      #1;
   endtask

   task automatic check_model(input string tag);
      chk({tag, " we"}, 32'(we), 32'(e_we));
      if (e_we) begin
         chk({tag, " addr"}, 32'(waddr), 32'(e_addr));
         chk({tag, " data"}, 32'(wdata), 32'(e_data));
      end
      chk({tag, " rd"}, 32'(rd), 32'(m_rd));
   endtask

   task automatic add(input bit r, input int s, input bit id, input bit w,
                      input int addr, input int data, input bit rdx);
      vec_t v;
      v.r = r; v.s = s; v.id = id; v.we = w; v.addr = addr; v.data = data; v.rd = rdx;
      tbl.push_back(v);
   endtask

   function automatic int rnd_sample();
      return int'($urandom_range(0, 65535)) - 32768;
   endfunction

   initial begin
      int neg_trig;
      reset  = 1'b1;
      ready  = 1'b0;
      sample = '0;
      idle   = 1'b0;
      model_reset();
`ifdef WAVE_TRIGGER_HYST_EN
      neg_trig = -2000;
`else
      neg_trig = -1;
`endif

      #1;
      chk("reset we", 32'(we), 32'd0);
      chk("reset addr", 32'(waddr), 32'd0);
      chk("reset data", 32'(wdata), 32'd0);
      chk("reset rd", 32'(rd), 32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;

      // ---- table-driven vectors ----
`ifdef WAVE_TRIGGER_HYST_EN
      add(1, -10,   0, 0, 0,     0,    0);
      add(1, 10,    0, 0, 0,     0,    0);
      add(1, -2000, 0, 0, 0,     0,    0);
      add(1, 10,    0, 1, 'h100, 'h80, 0);
`else
      add(1, 5,     0, 0, 0,     0,    0);
      add(1, -5,    0, 0, 0,     0,    0);
      add(1, 3,     0, 1, 'h100, 'h80, 0);
`endif
      add(1, -32768, 0, 1, 'h101, 'h00, 0);
      add(1, 0,      0, 1, 'h102, 'h80, 0);
      add(0, 0,      1, 0, 0,     0,    0);
      add(1, 32767,  0, 1, 'h103, 'hFF, 0);
      add(1, -256,   0, 1, 'h104, 'h7F, 0);

      for (int i = 0; i < tbl.size(); i++) begin
         tick(tbl[i].r, tbl[i].s, tbl[i].id);
         chk($sformatf("vec%0d we", i), 32'(we), 32'(tbl[i].we));
         if (tbl[i].we) begin
            chk($sformatf("vec%0d addr", i), 32'(waddr), 32'(tbl[i].addr));
            chk($sformatf("vec%0d data", i), 32'(wdata), 32'(tbl[i].data));
         end
         chk($sformatf("vec%0d rd", i), 32'(rd), 32'(tbl[i].rd));
      end

      // ---- finish the capture with a ramp, back-to-back strobes ----
      for (int i = 0; i < N && m_pos < N; i++) begin
         tick(1, (i * 256) - 32768, 0);
         check_model("ramp");
      end
      chk("ramp last addr", 32'(waddr), 32'h1FF);

      // ---- WAIT with display busy: no writes, no toggle ----
      for (int i = 0; i < 50; i++) begin
         tick(1, (i % 2 == 0) ? -100 : 100, 0);
         check_model("wait");
      end
      chk("wait rd held", 32'(rd), 32'd0);
      tick(0, 0, 1);
      check_model("flip");
      chk("flip rd", 32'(rd), 32'd1);
      tick(0, 0, 1);
      chk("flip once", 32'(rd), 32'd1);

      // ---- second capture goes to the lower half ----
      tick(1, neg_trig, 0);
      check_model("cap2 neg");
      tick(1, 3, 0);
      check_model("cap2 trig");
      chk("cap2 addr", 32'(waddr), 32'h000);
      for (int i = 0; i < N && m_pos < 100; i++) begin
         tick(1, rnd_sample(), 0);
         check_model("cap2");
      end

      // ---- reset in the middle of a capture ----
      chk("pre-reset we", 32'(we), 32'd1);
      @(negedge clk);
      ready  = 1'b1;
      sample = 16'sd1234;
      reset  = 1'b1;
      #1;
      chk("midrst we", 32'(we), 32'd0);
      chk("midrst rd", 32'(rd), 32'd0);
      @(posedge clk);
      #1;
      chk("midrst we hold", 32'(we), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      ready = 1'b0;
      model_reset();
      tick(1, neg_trig, 0);
      check_model("post-rst neg");
      tick(1, 1, 0);
      check_model("post-rst trig");
      chk("post-rst addr", 32'(waddr), 32'h100);
      chk("post-rst data", 32'(wdata), 32'h80);

      // ---- randomized traffic against the model ----
      for (int i = 0; i < 6000; i++) begin
         bit r;
         bit id;
         r  = ((i / 400) % 2 == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
         id = ($urandom_range(0, 3) == 0);
         tick(r, rnd_sample(), id);
         check_model("rand");
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/wave_trigger_capture.md
Name: wave_trigger_capture

Overview:
Capture front end for the waveform display. Watches the 16-bit signed audio sample stream and waits for a positive-going zero crossing. It then writes 256 consecutive samples, converted to 8-bit offset-binary, into one half of the display's double-buffered RAM. Once the display is idle, it flips the buffer so the display reads the fresh half while the next capture goes into the other half. Feeds the write port of the sample RAM and drives read_index to wave_display.

Parameters:
NUM_SAMPLES_LOG2, 8, log2 of samples per capture; write_address width is NUM_SAMPLES_LOG2+1
HYST_LEVEL, 16'd1024, magnitude below zero a sample must reach before re-arming (used only with the optional feature)

Ports:
clk  input  1  system clock; sole clock domain
reset  input  1  asynchronous, active-high; clears all state
new_sample_ready  input  1  one-cycle strobe; new_sample_in is valid this cycle
new_sample_in  input  16  signed two's-complement audio sample
wave_display_idle  input  1  high while the display is not reading RAM (driven from ~vsync)
write_address  output  NUM_SAMPLES_LOG2+1  {~read_index, sample_count}
write_enable  output  1  RAM write strobe
write_sample  output  8  {~new_sample_in[15], new_sample_in[14:8]}
read_index  output  1  buffer half the display reads

Behaviour:
- All outputs registered. Reset values: write_enable=0, write_address=0, write_sample=0, read_index=0, state=ARMED, sample_count=0, prev_sample=0.
- prev_sample captures new_sample_in on every new_sample_ready, in every state.
- Crossing condition: prev_sample[15]==1 and new_sample_in[15]==0 on a new_sample_ready cycle.
- Because prev_sample resets to 0, the first sample after reset cannot trigger.
- ARMED:
  - Crossing → write the crossing sample at count 0, set sample_count=1, go to ACTIVE.
  - No crossing → no write.
- ACTIVE:
  - Each new_sample_ready writes at the current sample_count, then increments it.
  - The write at count 2^NUM_SAMPLES_LOG2-1 (255) wraps sample_count to 0 and goes to WAIT.
  - Exactly 256 writes occur per capture.
- WAIT:
  - new_sample_ready causes no write; prev_sample still updates.
  - When wave_display_idle is high: toggle read_index, go to ARMED.
- wave_display_idle is ignored in ARMED and ACTIVE. Toggling happens only in WAIT, so the display never reads a half-written buffer.
- Write latency: the write_enable/write_address/write_sample triple appears one cycle after the accepted new_sample_ready and is high for exactly one cycle.
  - write_address[MSB] = ~read_index as sampled at the time of the write.
  - Capture always targets the half the display is not reading.
- Back-to-back new_sample_ready strobes on consecutive cycles must each be written; no strobes are dropped in ACTIVE.
- Reset mid-capture: returns to ARMED, read_index=0, and any pending write is cancelled (write_enable=0 immediately).
- Width rule: the upper byte is used and the MSB is inverted, so -32768 maps to 0x00, 0 maps to 0x80, and 32767 maps to 0xFF.

Optional Feature:
Macro: WAVE_TRIGGER_HYST_EN.
- Defined:
  - An internal armed_low flag clears on entry to ARMED and at reset.
  - The flag sets when a sample with signed value <= -HYST_LEVEL arrives while in ARMED.
  - A crossing triggers only if armed_low=1.
  - This rejects triggers on small noise around zero.
- Undefined: plain sign-change crossing as above. HYST_LEVEL is unused and there is no armed_low register.

Test Plan:
- Reset, then samples -5, +3 → one write at address 0x100 (read_index=0 so MSB=1), data 0x80, state ACTIVE.
- After a trigger, feed 255 more ramp samples → 256 write strobes at addresses 0x100..0x1FF, then no further writes. Hold idle=1 → read_index becomes 1; the next capture writes 0x000..0x0FF.
- In WAIT with idle=0, apply 50 strobes → no write_enable and read_index unchanged. Raise idle → exactly one toggle.
- Assert reset at capture count 100 → next cycle write_enable=0, read_index=0, state ARMED. Sample -1 then +1 → write at 0x100.
- Data mapping: trigger, then samples 0x8000, 0x0000, 0x7FFF, 0xFF00 → write_sample 0x00, 0x80, 0xFF, 0x7F.
- With WAVE_TRIGGER_HYST_EN: samples -10, +10 → no trigger. Then -2000, +10 → trigger; first write data 0x80.
